// File: rtl/wm_buzz_ctrl.sv
// Beep-pattern scheduler: shares one buzzer between key-click, cycle-end and error-alarm requesters.
// Latency: a request sampled at edge n gives START at edge n+1; buzStart is high exactly for the START cycle.
// Requests are held in single-deep pend flags; a repeat request while pending is absorbed.
module wm_buzz_ctrl #(
  parameter int TICK_ON   = 200,
  parameter int TICK_GAP  = 200,
  parameter int KEY_BEEPS = 1,
  parameter int END_BEEPS = 3,
  parameter int ERR_BEEPS = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick,
  input  logic       keyReq,
  input  logic       endReq,
  input  logic       errReq,
  input  logic       mute,
  output logic       buzStart,
  output logic       busy,
  output logic [1:0] curPat
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_ON, S_GAP} state_t;

  localparam logic [9:0] ON_LAST  = 10'(TICK_ON - 1);
  localparam logic [9:0] GAP_LAST = 10'(TICK_GAP - 1);
  localparam logic [3:0] KEY_LEFT = 4'(KEY_BEEPS - 1);
  localparam logic [3:0] END_LEFT = 4'(END_BEEPS - 1);
  localparam logic [3:0] ERR_LEFT = 4'(ERR_BEEPS - 1);

  localparam logic [1:0] PAT_NONE = 2'd0;
  localparam logic [1:0] PAT_KEY  = 2'd1;
  localparam logic [1:0] PAT_END  = 2'd2;
  localparam logic [1:0] PAT_ERR  = 2'd3;

  state_t     state;
  logic [9:0] tick_cnt;
  logic [3:0] beeps_left;
  logic       pend_key;
  logic       pend_end;
  logic       pend_err;
  logic       acc_key;
  logic       acc_end;
  logic       acc_err;

  // Acceptance: IDLE takes the highest-priority pending pattern; err may also cut into a running key/end pattern.
  always_comb begin
    acc_err = 1'b0;
    acc_end = 1'b0;
    acc_key = 1'b0;
    if (!mute) begin
      if (state == S_IDLE) begin
        acc_err = pend_err;
        acc_end = !pend_err && pend_end;
        acc_key = !pend_err && !pend_end && pend_key;
      end else if ((state == S_ON || state == S_GAP) &&
                   (curPat == PAT_KEY || curPat == PAT_END)) begin
        acc_err = pend_err;
      end
    end
  end

  // Pend flags: latch unmuted requests; a request on its own accept edge re-arms the flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_key <= 1'b0;
      pend_end <= 1'b0;
      pend_err <= 1'b0;
    end else if (mute) begin
      pend_key <= 1'b0;
      pend_end <= 1'b0;
      pend_err <= 1'b0;
    end else begin
      pend_key <= (pend_key && !acc_key) || keyReq;
      pend_end <= (pend_end && !acc_end) || endReq;
      pend_err <= (pend_err && !acc_err) || errReq;
    end
  end

  // Pattern sequencer: START -> ON (TICK_ON ticks) -> GAP (TICK_GAP ticks) -> START ... until beeps run out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      beeps_left <= '0;
      curPat     <= PAT_NONE;
    end else if (mute) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      beeps_left <= '0;
      curPat     <= PAT_NONE;
    end else if (acc_err) begin
      state      <= S_START;
      beeps_left <= ERR_LEFT;
      curPat     <= PAT_ERR;
    end else if (acc_end) begin
      state      <= S_START;
      beeps_left <= END_LEFT;
      curPat     <= PAT_END;
    end else if (acc_key) begin
      state      <= S_START;
      beeps_left <= KEY_LEFT;
      curPat     <= PAT_KEY;
    end else begin
      case (state)
        S_START: begin
          tick_cnt <= '0;
          state    <= S_ON;
        end
        S_ON: begin
          if (tick) begin
            if (tick_cnt == ON_LAST) begin
              tick_cnt <= '0;
              if (beeps_left != 4'd0) begin
                state <= S_GAP;
              end else begin
                state  <= S_IDLE;
                curPat <= PAT_NONE;
              end
            end else begin
              tick_cnt <= tick_cnt + 10'd1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (tick_cnt == GAP_LAST) begin
              tick_cnt   <= '0;
              beeps_left <= beeps_left - 4'd1;
              state      <= S_START;
            end else begin
              tick_cnt <= tick_cnt + 10'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign buzStart = (state == S_START);
  assign busy     = (state != S_IDLE);

endmodule
